input_fetch_sequencer: RTL

//  Sits directly downstream of the input buffer. On start, reads entries 0..synopseFold-1 via the

---
 rtl/input_fetch_sequencer_if.sv | 31 +++
 rtl/input_fetch_sequencer.sv | 104 ++++++++++
 2 files changed

// File: rtl/input_fetch_sequencer_if.sv
// Buffer read port and PE-array output stream bundled
// for the input fetch sequencer.
interface input_fetch_sequencer_if #(
  parameter int AW = 12,
  parameter int W  = 64
);
  logic          buf_enable;
  logic          buf_rwEn;
  logic [AW-1:0] buf_address;
  logic [W-1:0]  buf_data;
  logic          buf_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [15:0]   out_fold;

  modport master (
    output buf_enable, buf_rwEn, buf_address,
    input  buf_data, buf_ready,
    output out_data, out_valid, out_last, out_fold,
    input  out_ready
  );

  modport slave (
    input  buf_enable, buf_rwEn, buf_address,
    output buf_data, buf_ready,
    input  out_data, out_valid, out_last, out_fold,
    output out_ready
  );
endinterface

// File: rtl/input_fetch_sequencer.sv
// Reads buffer words 0..synopseFold-1 once per neuron fold and
// streams them to the PE array, tagging the last word of each pass.
module input_fetch_sequencer #(
  parameter int address_width       = 12,
  parameter int synopseFold         = 18,
  parameter int neuronFold          = 16,
  parameter int simd_width          = 32,
  parameter int binary_input_levels = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  input_fetch_sequencer_if.master bus
);
  localparam int WCW = (synopseFold > 1) ? $clog2(synopseFold) : 1;
  localparam int FCW = (neuronFold > 1) ? $clog2(neuronFold) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(synopseFold - 1);
  localparam logic [FCW-1:0] FLAST = FCW'(neuronFold - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DONE
  } state_t;

  state_t         state;
  logic [WCW-1:0] word_cnt;
  logic [FCW-1:0] fold_cnt;

  assign bus.buf_rwEn    = 1'b1;
  assign bus.buf_address = address_width'(word_cnt);
  assign bus.out_fold    = 16'(fold_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      word_cnt       <= '0;
      fold_cnt       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      bus.buf_enable <= 1'b0;
      bus.out_data   <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_last   <= 1'b0;
    end else begin
      done <= 1'b0;
      // abort outranks everything, including a same-cycle handshake
      if (state != S_IDLE && abort) begin
        state          <= S_IDLE;
        busy           <= 1'b0;
        bus.buf_enable <= 1'b0;
        bus.out_valid  <= 1'b0;
        bus.out_last   <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start && !abort) begin
              word_cnt       <= '0;
              fold_cnt       <= '0;
              busy           <= 1'b1;
              bus.buf_enable <= 1'b1;
              state          <= S_REQ;
            end
          end
          S_REQ: state <= S_WAIT;
          S_WAIT: begin
            if (bus.buf_ready) begin
              bus.out_data   <= bus.buf_data;
              bus.out_valid  <= 1'b1;
              bus.out_last   <= (word_cnt == WLAST);
              bus.buf_enable <= 1'b0;
              state          <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (bus.out_ready) begin
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              if (word_cnt != WLAST) begin
                word_cnt       <= word_cnt + 1'b1;
                bus.buf_enable <= 1'b1;
                state          <= S_REQ;
              end else if (fold_cnt != FLAST) begin
                word_cnt       <= '0;
                fold_cnt       <= fold_cnt + 1'b1;
                bus.buf_enable <= 1'b1;
                state          <= S_REQ;
              end else begin
                done  <= 1'b1;
                state <= S_DONE;
              end
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
